// File: rtl/flop_add_seq.sv
// flop_add_seq: multi-cycle truncating float add/sub with explicit-mantissa words
module flop_add_seq #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_res,
  output logic                     out_ovf,
  output logic                     out_unf
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int CW = $clog2(MAN_W + 1);
  typedef enum logic [2:0] {IDLE, SWAP, ALIGN, ADD, NORM, OUT} state_t;
  state_t           r_state;
  logic [W-1:0]     r_a, r_b;
  logic             r_sign, r_sub, r_ovf, r_unf, r_ovalid;
  logic [EXP_W-1:0] r_exp;
  logic [MAN_W-1:0] r_man, r_sm;
  logic [CW-1:0]    r_cnt;
  logic             w_a_big;
  logic [W-1:0]     w_big, w_sml;
  logic [EXP_W-1:0] w_d;
  logic [CW-1:0]    w_cnt;
  logic [MAN_W:0]   w_sum;
  logic [MAN_W-1:0] w_man_sh;
  assign w_a_big  = r_a[W-2:0] >= r_b[W-2:0];
  assign w_big    = w_a_big ? r_a : r_b;
  assign w_sml    = w_a_big ? r_b : r_a;
  assign w_d      = w_big[W-2:MAN_W] - w_sml[W-2:MAN_W];
  assign w_cnt    = ({{(32-EXP_W){1'b0}}, w_d} > MAN_W) ? CW'(MAN_W) : CW'(w_d);
  assign w_sum    = r_sub ? {1'b0, r_man} - {1'b0, r_sm} : {1'b0, r_man} + {1'b0, r_sm};
  assign w_man_sh = r_man << 1;
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_ovalid;
  assign out_res   = {r_sign, r_exp, r_man};
  assign out_ovf   = r_ovf;
  assign out_unf   = r_unf;
  // Sequencer and datapath: capture, order by magnitude, align, add, normalize, present
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sign   <= 1'b0;
      r_sub    <= 1'b0;
      r_exp    <= '0;
      r_man    <= '0;
      r_sm     <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_ovalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a     <= in_a;
          r_b     <= {in_b[W-1] ^ in_op, in_b[W-2:0]};
          r_ovf   <= 1'b0;
          r_unf   <= 1'b0;
          r_state <= SWAP;
        end
        SWAP: begin
          r_sign  <= w_big[W-1];
          r_exp   <= w_big[W-2:MAN_W];
          r_man   <= w_big[MAN_W-1:0];
          r_sm    <= w_sml[MAN_W-1:0];
          r_sub   <= w_big[W-1] ^ w_sml[W-1];
          r_cnt   <= w_cnt;
          r_state <= (w_cnt != '0) ? ALIGN : ADD;
        end
        ALIGN: begin
          r_sm  <= r_sm >> 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= ADD;
        end
        ADD: begin
          if (!r_sub && w_sum[MAN_W]) begin
            if (&r_exp) begin
              r_man <= '1;
              r_ovf <= 1'b1;
            end else begin
              r_man <= w_sum[MAN_W:1];
              r_exp <= r_exp + 1'b1;
            end
            r_state  <= OUT;
            r_ovalid <= 1'b1;
          end else if (w_sum == '0) begin
            {r_sign, r_exp, r_man} <= '0;
            r_state  <= OUT;
            r_ovalid <= 1'b1;
          end else begin
            r_man <= w_sum[MAN_W-1:0];
            if (w_sum[MAN_W-1]) begin
              r_state  <= OUT;
              r_ovalid <= 1'b1;
            end else r_state <= NORM;
          end
        end
        NORM: begin
          if (r_exp == '0) begin
            {r_sign, r_exp, r_man} <= '0;
            r_unf    <= 1'b1;
            r_state  <= OUT;
            r_ovalid <= 1'b1;
          end else begin
            r_man <= w_man_sh;
            r_exp <= r_exp - 1'b1;
            if (w_man_sh[MAN_W-1]) begin
              r_state  <= OUT;
              r_ovalid <= 1'b1;
            end
          end
        end
        OUT: if (out_ready) begin
          r_ovalid <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_flop_add_seq.sv
// tb_flop_add_seq: randomized and directed checks of flop_add_seq against a numeric reference
module tb_flop_add_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] in_a = '0, in_b = '0;
  logic        in_op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [12:0] out_res;
  logic        out_ovf, out_unf;
  int n_chk = 0, n_bad = 0;

  flop_add_seq #(.EXP_W(4), .MAN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] mk(input int s, input int e, input int m);
    return 13'(s * 4096 + e * 256 + m);
  endfunction

  task automatic model(input logic [12:0] a, input logic [12:0] b, input logic op,
                       output logic [12:0] res, output logic ovf, output logic unf, output int lat);
    int sa, ea, ma, sb, eb, mb, bs, be, bm, se, sm, sh, s, e, m;
    sa = int'(a[12]); ea = int'(a[11:8]); ma = int'(a[7:0]);
    sb = int'(b[12] ^ op); eb = int'(b[11:8]); mb = int'(b[7:0]);
    if (ea * 256 + ma >= eb * 256 + mb) begin
      bs = sa; be = ea; bm = ma; se = eb; sm = mb;
    end else begin
      bs = sb; be = eb; bm = mb; se = ea; sm = ma;
    end
    sh = be - se;
    if (sh > 8) sh = 8;
    sm = sm >> sh;
    lat = 2 + sh;
    ovf = 1'b0;
    unf = 1'b0;
    if ((bs == (ea * 256 + ma >= eb * 256 + mb ? sb : sa))) begin
      s = bm + sm;
      if (s > 255) begin
        if (be == 15) begin
          res = mk(bs, 15, 255);
          ovf = 1'b1;
        end else res = mk(bs, be + 1, s / 2);
      end else res = (s == 0) ? 13'h0 : mk(bs, be, s);
    end else begin
      m = bm - sm;
      e = be;
      if (m == 0) res = 13'h0;
      else begin
        while (m < 128 && !unf) begin
          lat++;
          if (e == 0) unf = 1'b1;
          else begin
            m = m * 2;
            e = e - 1;
          end
        end
        res = unf ? 13'h0 : mk(bs, e, m);
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [12:0] a, input logic [12:0] b, input logic op,
                        input int hold, input logic [12:0] eres, input logic eovf, input logic eunf,
                        input int elat);
    int n;
    logic [14:0] held;
    chk({tag, "_rdy"}, in_ready, 1);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 13'($urandom); in_b = 13'($urandom); in_op = 1'($urandom); in_valid = 1'($urandom);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_res"}, out_res, eres);
    chk({tag, "_flg"}, {out_ovf, out_unf}, {eovf, eunf});
    held = {out_res, out_ovf, out_unf};
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk({tag, "_hold"}, {out_valid, in_ready, out_res, out_ovf, out_unf}, {1'b1, 1'b0, held});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_done"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [12:0] a, b, r;
    logic op, ov, un, seen;
    int lat;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {in_ready, out_valid, out_res, out_ovf, out_unf}, {1'b1, 1'b0, 13'h0, 2'b00});
    rst_n = 1'b1;
    run_op("add_align", mk(0, 3, 'hC0), mk(0, 2, 'h80), 1'b0, 0, 13'h0480, 1'b0, 1'b0, 3);
    run_op("sub_zero", mk(0, 5, 'h90), mk(0, 5, 'h90), 1'b1, 0, 13'h0000, 1'b0, 1'b0, 2);
    run_op("sub_norm", mk(0, 5, 'h90), mk(1, 5, 'h80), 1'b0, 0, 13'h0280, 1'b0, 1'b0, 5);
    run_op("ovf", mk(0, 15, 'hFF), mk(0, 15, 'hFF), 1'b0, 0, 13'h0FFF, 1'b1, 1'b0, 2);
    run_op("unf", mk(0, 1, 'h90), mk(1, 1, 'h80), 1'b0, 0, 13'h0000, 1'b0, 1'b1, 4);
    run_op("hold5", mk(1, 7, 'hA0), mk(1, 6, 'h80), 1'b0, 5, mk(1, 7, 'hE0), 1'b0, 1'b0, 3);
    run_op("far", mk(0, 14, 'h81), mk(0, 1, 'hFF), 1'b0, 0, mk(0, 14, 'h81), 1'b0, 1'b0, 10);
    in_a = mk(0, 8, 'h80); in_b = mk(0, 2, 'h80); in_op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_rst", {out_valid, in_ready, out_res}, {1'b0, 1'b1, 13'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("abort_quiet", {seen, in_ready}, 2'b01);
    for (int i = 0; i < 60; i++) begin
      a = {1'($urandom), 4'($urandom), 1'b1, 7'($urandom)};
      b = {1'($urandom), 4'($urandom), 1'b1, 7'($urandom)};
      if ($urandom_range(0, 2) == 0) b = {1'($urandom), a[11:8], 1'b1, a[6:0] ^ 7'($urandom_range(0, 7))};
      op = 1'($urandom);
      model(a, b, op, r, ov, un, lat);
      run_op($sformatf("rnd%0d", i), a, b, op, $urandom_range(0, 3), r, ov, un, lat);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
